mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multicycle MIPS control unit: a Moore FSM that sequences fetch/decode/execute/memory/writeback.
- It is the producer side of the 32-bit ALU interface:
  - drives the 4-bit alu_control and shamt-select timing;
  - consumes zero and LTEZ for branch resolution.
- Sits in the multicycle datapath top, next to the register file, instruction register and unified memory.

Parameters:
- ENABLE_BLEZ, 1, when 0 the BLEZ opcode is treated as illegal.

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- op  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- zero  in  1  ALU result == 0
- ltez  in  1  ALU result <= 0 (signed)
- alu_control  out  4  [3]=invert b / carry-in, [2:0]: 000 AND, 001 OR, 010 ADD, 011 SLT, 100 SLL
- alusrca  out  1  0=PC, 1=reg A
- alusrcb  out  2  00=reg B, 01=const 4, 10=signimm, 11=signimm<<2
- iord  out  1  memory address: 0=PC, 1=ALUOut
- irwrite  out  1  load instruction register
- memwrite  out  1  memory write enable
- regwrite  out  1  register file write enable
- regdst  out  1  0=rt, 1=rd
- memtoreg  out  1  0=ALUOut, 1=Data
- pcsrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
- pcen  out  1  PC register enable
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported op/funct

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQ, BLEZ, ADDIEX, ADDIWB, JUMP.
- Reset:
  - reset low forces state=FETCH asynchronously.
  - While reset is low, all enables (irwrite, memwrite, regwrite, pcen) are 0 and illegal_op=0.
  - Other outputs take FETCH values.
  - First FETCH action happens on the first rising edge after reset deasserts.
- Outputs are Moore, decoded from the state only, except:
  - pcen = pcwrite | (branch_eq & zero) | (branch_lez & ltez);
  - alu_control, which in RTYPEEX also depends on funct.
- Per-state actions (unlisted enables are 0):
  - FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, alu_control=ADD(0010), pcsrc=00, pcwrite=1. Next state: DECODE.
  - DECODE: alusrca=0, alusrcb=11, ADD (branch target into ALUOut). Next state by op:
    - 100011/101011 -> MEMADR
    - 000000 -> RTYPEEX
    - 000100 -> BEQ
    - 000110 -> BLEZ
    - 001000 -> ADDIEX
    - 000010 -> JUMP
    - else illegal_op=1 and next state FETCH.
  - DECODE also checks R-type funct: if not in {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 000000 sll}, then illegal_op=1 and next state FETCH.
  - MEMADR: alusrca=1, alusrcb=10, ADD. Next state: lw -> MEMRD, sw -> MEMWR.
  - MEMRD: iord=1. Next state: MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1. Next state: FETCH.
  - MEMWR: iord=1, memwrite=1. Next state: FETCH.
  - RTYPEEX: alusrca=1, alusrcb=00, alu_control from funct (add 0010, sub 1010, and 0000, or 0001, slt 1011, sll 0100). Next state: RTYPEWB.
  - RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Next state: FETCH.
  - BEQ: alusrca=1, alusrcb=00, SUB(1010), pcsrc=01, branch_eq=1. Next state: FETCH.
  - BLEZ: alusrca=1, alusrcb=00 (rt=$0, so B=0), SUB(1010), pcsrc=01, branch_lez=1. Next state: FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, ADD. Next state: ADDIWB.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next state: FETCH.
  - JUMP: pcsrc=10, pcwrite=1. Next state: FETCH.
- Latencies (cycles):
  - lw 5; sw 4; R-type 4; addi 4; beq 3; blez 3; j 3; illegal 2.
- sll encoding:
  - sll with all-zero instruction (nop) is legal and writes $0.
  - The register file discards the $0 write.
- pcen depends combinationally on zero/ltez only in BEQ/BLEZ. In every other state it equals pcwrite.
- Reset asserted mid-instruction: state returns to FETCH immediately. No partial write may complete after reset falls, because enables gate low asynchronously.
- Undefined state encodings recover to FETCH on the next edge.

Decomposition:
- Package mc_pkg holds:
  - state enum statetype;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BLEZ, OP_ADDI, OP_J);
  - funct constants;
  - ALU control constants (ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=1010, ALU_SLT=1011, ALU_SLL=0100);
  - 2-bit aluop enum (ADD, SUB, FUNCT).
- One sub-module, alu_decoder: combinational (aluop, funct) -> alu_control plus funct_legal.
- The FSM stays in mc_controller.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release. Required: pcen=irwrite=regwrite=memwrite=0 during reset. First edge after release is in FETCH with irwrite=1, pcen=1, alu_control=0010, alusrcb=01.
- lw: op=100011. Required state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB. MEMRD has iord=1; MEMWB has regwrite=1, memtoreg=1, regdst=0; then back to FETCH (5 cycles).
- R-type sweep: op=0, funct in {20h,22h,24h,25h,2Ah,00h}. Required alu_control in RTYPEEX = {0010,1010,0000,0001,1011,0100}; RTYPEWB has regwrite=1, regdst=1.
- beq: in BEQ drive zero=1 -> pcen=1, pcsrc=01, alu_control=1010; drive zero=0 -> pcen=0. Next state FETCH in both cases.
- blez: in BLEZ drive ltez=1, zero=0 -> pcen=1; drive ltez=0 -> pcen=0. With ENABLE_BLEZ=0, op=000110 gives illegal_op=1 in DECODE and returns to FETCH.
- Illegal and mid-op reset:
  - op=111111 -> illegal_op pulse for 1 cycle, next FETCH.
  - funct=000111 with op=0 -> same result.
  - reset=0 asserted during MEMWR -> memwrite drops to 0 the same cycle and state=FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
// Also holds the per-state Moore control table used by the FSM.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX,
    RTYPEWB, BEQ, BLEZ, ADDIEX, ADDIWB, JUMP
  } statetype;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b1010;
  localparam logic [3:0] ALU_SLT = 4'b1011;
  localparam logic [3:0] ALU_SLL = 4'b0100;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef struct packed {
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch_eq;
    logic       branch_lez;
    aluop_t     aluop;
  } ctl_t;

  function automatic ctl_t state_ctl(input statetype s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:   begin c.irwrite = 1'b1; c.alusrcb = 2'b01; c.pcwrite = 1'b1; end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      MEMRD:   c.iord = 1'b1;
      MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      RTYPEEX: begin c.alusrca = 1'b1; c.aluop = ALUOP_FUNCT; end
      RTYPEWB: begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      BEQ:     begin c.alusrca = 1'b1; c.aluop = ALUOP_SUB; c.pcsrc = 2'b01; c.branch_eq = 1'b1; end
      BLEZ:    begin c.alusrca = 1'b1; c.aluop = ALUOP_SUB; c.pcsrc = 2'b01; c.branch_lez = 1'b1; end
      ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      ADDIWB:  c.regwrite = 1'b1;
      JUMP:    begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// Combinational ALU decoder: maps (aluop, funct) to the 4-bit ALU control
// and flags whether funct names a supported R-type operation.
module alu_decoder
  import mc_pkg::*;
(
  input  aluop_t      i_aluop,
  input  logic [5:0]  i_funct,
  output logic [3:0]  o_alu_control,
  output logic        o_funct_legal
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_aluop)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  o_alu_control = ALU_ADD;
          FN_SUB:  o_alu_control = ALU_SUB;
          FN_AND:  o_alu_control = ALU_AND;
          FN_OR:   o_alu_control = ALU_OR;
          FN_SLT:  o_alu_control = ALU_SLT;
          FN_SLL:  o_alu_control = ALU_SLL;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

  always_comb begin
    case (i_funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL: o_funct_legal = 1'b1;
      default:                                       o_funct_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM. Control outputs are registered from the next
// state so they are glitch-free Moore values; enables are gated by reset.
module mc_controller
  import mc_pkg::*;
#(
  parameter bit ENABLE_BLEZ = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       ltez,
  output logic [3:0] alu_control,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       illegal_op
);

  statetype r_state;
  statetype w_next;
  ctl_t     r_ctl;
  logic     w_funct_legal;
  logic     w_decode_ok;

  always_comb begin
    case (op)
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: w_decode_ok = 1'b1;
      OP_RTYPE:                            w_decode_ok = w_funct_legal;
      OP_BLEZ:                             w_decode_ok = ENABLE_BLEZ;
      default:                             w_decode_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH: w_next = DECODE;
      DECODE: begin
        if (w_decode_ok) begin
          case (op)
            OP_LW, OP_SW: w_next = MEMADR;
            OP_RTYPE:     w_next = RTYPEEX;
            OP_BEQ:       w_next = BEQ;
            OP_BLEZ:      w_next = BLEZ;
            OP_ADDI:      w_next = ADDIEX;
            OP_J:         w_next = JUMP;
            default:      w_next = FETCH;
          endcase
        end
      end
      MEMADR:  w_next = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   w_next = MEMWB;
      RTYPEEX: w_next = RTYPEWB;
      ADDIEX:  w_next = ADDIWB;
      default: w_next = FETCH;
    endcase
  end

  // Outputs for the state being entered are latched alongside it; the reset
  // value is the FETCH row so non-enable outputs show FETCH while held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FETCH;
      r_ctl   <= state_ctl(FETCH);
    end else begin
      r_state <= w_next;
      r_ctl   <= state_ctl(w_next);
    end
  end

  alu_decoder u_alu_decoder (
    .i_aluop       (r_ctl.aluop),
    .i_funct       (funct),
    .o_alu_control (alu_control),
    .o_funct_legal (w_funct_legal)
  );

  assign alusrca  = r_ctl.alusrca;
  assign alusrcb  = r_ctl.alusrcb;
  assign iord     = r_ctl.iord;
  assign regdst   = r_ctl.regdst;
  assign memtoreg = r_ctl.memtoreg;
  assign pcsrc    = r_ctl.pcsrc;

  assign irwrite    = r_ctl.irwrite  & reset;
  assign memwrite   = r_ctl.memwrite & reset;
  assign regwrite   = r_ctl.regwrite & reset;
  assign pcen       = (r_ctl.pcwrite | (r_ctl.branch_eq & zero) |
                       (r_ctl.branch_lez & ltez)) & reset;
  assign illegal_op = (r_state == DECODE) & ~w_decode_ok & reset;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction phase sequences and expected
// control rows are built from the instruction set rules, not the RTL.
module tb_mc_controller;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic zero = 1'b0;
  logic ltez = 1'b0;

  logic [3:0] a_alu, b_alu;
  logic a_asa, b_asa, a_iord, b_iord, a_irw, b_irw, a_mw, b_mw, a_rw, b_rw;
  logic a_rd, b_rd, a_m2r, b_m2r, a_pcen, b_pcen, a_ill, b_ill;
  logic [1:0] a_asb, b_asb, a_pcs, b_pcs;

  typedef struct packed {
    logic [3:0] alu;
    logic       asa;
    logic [1:0] asb;
    logic       iord, irw, mw, rw, rd, m2r;
    logic [1:0] pcs;
    logic       pcen, ill;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  string seq[$];
  bit seq_ill;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .ltez(ltez),
    .alu_control(a_alu), .alusrca(a_asa), .alusrcb(a_asb), .iord(a_iord),
    .irwrite(a_irw), .memwrite(a_mw), .regwrite(a_rw), .regdst(a_rd),
    .memtoreg(a_m2r), .pcsrc(a_pcs), .pcen(a_pcen), .illegal_op(a_ill)
  );

  mc_controller #(.ENABLE_BLEZ(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .ltez(ltez),
    .alu_control(b_alu), .alusrca(b_asa), .alusrcb(b_asb), .iord(b_iord),
    .irwrite(b_irw), .memwrite(b_mw), .regwrite(b_rw), .regdst(b_rd),
    .memtoreg(b_m2r), .pcsrc(b_pcs), .pcen(b_pcen), .illegal_op(b_ill)
  );

  function automatic logic [3:0] fn_alu(input logic [5:0] f);
    case (f)
      6'h20:   return 4'b0010;
      6'h22:   return 4'b1010;
      6'h24:   return 4'b0000;
      6'h25:   return 4'b0001;
      6'h2A:   return 4'b1011;
      default: return 4'b0100;
    endcase
  endfunction

  // Expected row and care-mask for one cycle of a given phase.
  function automatic void model(input string ph, input logic [5:0] fn, input bit ill,
                                output vec_t ev, output vec_t mk);
    ev = '0; mk = '0;
    mk.irw = 1; mk.mw = 1; mk.rw = 1; mk.pcen = 1; mk.ill = 1;
    case (ph)
      "RESET":   begin ev.alu = 4'b0010; ev.asb = 2'b01;
                   mk.alu = '1; mk.asa = 1; mk.asb = '1; mk.iord = 1; mk.pcs = '1; end
      "FETCH":   begin ev.alu = 4'b0010; ev.asb = 2'b01; ev.irw = 1; ev.pcen = 1;
                   mk.alu = '1; mk.asa = 1; mk.asb = '1; mk.iord = 1; mk.pcs = '1; end
      "DECODE":  begin ev.alu = 4'b0010; ev.asb = 2'b11; ev.ill = ill;
                   mk.alu = '1; mk.asa = 1; mk.asb = '1; end
      "MEMADR",
      "ADDIEX":  begin ev.alu = 4'b0010; ev.asa = 1; ev.asb = 2'b10;
                   mk.alu = '1; mk.asa = 1; mk.asb = '1; end
      "MEMRD":   begin ev.iord = 1; mk.iord = 1; end
      "MEMWB":   begin ev.m2r = 1; ev.rw = 1; mk.rd = 1; mk.m2r = 1; end
      "MEMWR":   begin ev.iord = 1; ev.mw = 1; mk.iord = 1; end
      "RTYPEEX": begin ev.alu = fn_alu(fn); ev.asa = 1;
                   mk.alu = '1; mk.asa = 1; mk.asb = '1; end
      "RTYPEWB": begin ev.rd = 1; ev.rw = 1; mk.rd = 1; mk.m2r = 1; end
      "ADDIWB":  begin ev.rw = 1; mk.rd = 1; mk.m2r = 1; end
      "BEQ",
      "BLEZ":    begin ev.alu = 4'b1010; ev.asa = 1; ev.pcs = 2'b01;
                   ev.pcen = (ph == "BEQ") ? zero : ltez;
                   mk.alu = '1; mk.asa = 1; mk.asb = '1; mk.pcs = '1; end
      "JUMP":    begin ev.pcs = 2'b10; ev.pcen = 1; mk.pcs = '1; end
      default:   ;
    endcase
  endfunction

  function automatic void build_seq(input logic [5:0] o, input logic [5:0] f, input bit en);
    seq.delete();
    seq.push_back("FETCH");
    seq.push_back("DECODE");
    seq_ill = 0;
    case (o)
      6'h23: begin seq.push_back("MEMADR"); seq.push_back("MEMRD"); seq.push_back("MEMWB"); end
      6'h2B: begin seq.push_back("MEMADR"); seq.push_back("MEMWR"); end
      6'h00: if (f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00}) begin
               seq.push_back("RTYPEEX"); seq.push_back("RTYPEWB");
             end else seq_ill = 1;
      6'h04: seq.push_back("BEQ");
      6'h06: if (en) seq.push_back("BLEZ"); else seq_ill = 1;
      6'h08: begin seq.push_back("ADDIEX"); seq.push_back("ADDIWB"); end
      6'h02: seq.push_back("JUMP");
      default: seq_ill = 1;
    endcase
  endfunction

  function automatic vec_t act(input bit nb);
    vec_t v;
    if (nb) v = {b_alu, b_asa, b_asb, b_iord, b_irw, b_mw, b_rw, b_rd, b_m2r, b_pcs, b_pcen, b_ill};
    else    v = {a_alu, a_asa, a_asb, a_iord, a_irw, a_mw, a_rw, a_rd, a_m2r, a_pcs, a_pcen, a_ill};
    return v;
  endfunction

  // Drive branch flags (negative = random), settle, and fetch model + DUT rows.
  task automatic sample(input string ph, input bit nb, input int zin, input int lzin,
                        output vec_t av, output vec_t ev, output vec_t mk);
    zero = (zin < 0) ? 1'($urandom_range(1, 0)) : (zin != 0);
    ltez = (lzin < 0) ? 1'($urandom_range(1, 0)) : (lzin != 0);
    #3;
    model(ph, funct, seq_ill, ev, mk);
    av = act(nb);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t av, ev, mk;
    reset = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      sample("RESET", 0, -1, -1, av, ev, mk);
      n_vec++;
      if ((av & mk) !== (ev & mk)) begin
        n_err++;
        $display("FAIL reset cyc%0d: got %h expected %h", i, av & mk, ev & mk);
      end
      next_cycle();
    end
    reset = 1;
  endtask

  task automatic test_lw();
    vec_t av, ev, mk;
    op = 6'h23; funct = 6'($urandom);
    build_seq(op, funct, 1);
    foreach (seq[i]) begin
      sample(seq[i], 0, -1, -1, av, ev, mk);
      n_vec++;
      if ((av & mk) !== (ev & mk)) begin
        n_err++;
        $display("FAIL lw %s: got %h expected %h", seq[i], av & mk, ev & mk);
      end
      next_cycle();
    end
  endtask

  task automatic test_rtype();
    vec_t av, ev, mk;
    logic [5:0] fl[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
    foreach (fl[k]) begin
      op = 6'h00; funct = fl[k];
      build_seq(op, funct, 1);
      foreach (seq[i]) begin
        sample(seq[i], 0, -1, -1, av, ev, mk);
        n_vec++;
        if ((av & mk) !== (ev & mk)) begin
          n_err++;
          $display("FAIL rtype f=%h %s: got %h expected %h", funct, seq[i], av & mk, ev & mk);
        end
        next_cycle();
      end
    end
  endtask

  task automatic test_beq();
    vec_t av, ev, mk;
    for (int z = 1; z >= 0; z--) begin
      op = 6'h04; funct = 6'($urandom);
      build_seq(op, funct, 1);
      foreach (seq[i]) begin
        sample(seq[i], 0, (seq[i] == "BEQ") ? z : -1, -1, av, ev, mk);
        n_vec++;
        if ((av & mk) !== (ev & mk)) begin
          n_err++;
          $display("FAIL beq z=%0d %s: got %h expected %h", z, seq[i], av & mk, ev & mk);
        end
        next_cycle();
      end
    end
  endtask

  task automatic test_blez();
    vec_t av, ev, mk;
    for (int lz = 1; lz >= 0; lz--) begin
      op = 6'h06; funct = 6'($urandom);
      build_seq(op, funct, 1);
      foreach (seq[i]) begin
        sample(seq[i], 0, (seq[i] == "BLEZ") ? 1 - lz : -1,
               (seq[i] == "BLEZ") ? lz : -1, av, ev, mk);
        n_vec++;
        if ((av & mk) !== (ev & mk)) begin
          n_err++;
          $display("FAIL blez lz=%0d %s: got %h expected %h", lz, seq[i], av & mk, ev & mk);
        end
        next_cycle();
      end
    end
  endtask

  task automatic test_blez_disabled();
    vec_t av, ev, mk;
    logic [5:0] ops[2] = '{6'h06, 6'h02};
    reset = 0; next_cycle(); reset = 1;
    foreach (ops[k]) begin
      op = ops[k]; funct = 6'($urandom);
      build_seq(op, funct, 0);
      foreach (seq[i]) begin
        sample(seq[i], 1, -1, -1, av, ev, mk);
        n_vec++;
        if ((av & mk) !== (ev & mk)) begin
          n_err++;
          $display("FAIL blez_off op=%h %s: got %h expected %h", op, seq[i], av & mk, ev & mk);
        end
        next_cycle();
      end
    end
    reset = 0; next_cycle(); reset = 1;
  endtask

  task automatic test_illegal();
    vec_t av, ev, mk;
    logic [5:0] ops[3] = '{6'h3F, 6'h00, 6'h02};
    logic [5:0] fns[3] = '{6'h20, 6'h07, 6'h00};
    foreach (ops[k]) begin
      op = ops[k]; funct = fns[k];
      build_seq(op, funct, 1);
      foreach (seq[i]) begin
        sample(seq[i], 0, -1, -1, av, ev, mk);
        n_vec++;
        if ((av & mk) !== (ev & mk)) begin
          n_err++;
          $display("FAIL illegal op=%h f=%h %s: got %h expected %h", op, funct, seq[i], av & mk, ev & mk);
        end
        next_cycle();
      end
    end
  endtask

  task automatic test_midop_reset();
    vec_t av, ev, mk;
    op = 6'h2B; funct = 6'($urandom);
    build_seq(op, funct, 1);
    foreach (seq[i]) begin
      sample(seq[i], 0, -1, -1, av, ev, mk);
      n_vec++;
      if ((av & mk) !== (ev & mk)) begin
        n_err++;
        $display("FAIL midrst sw %s: got %h expected %h", seq[i], av & mk, ev & mk);
      end
      if (seq[i] == "MEMWR") begin
        #1 reset = 0;
        #1;
        model("RESET", funct, 0, ev, mk);
        av = act(0);
        n_vec++;
        if ((av & mk) !== (ev & mk)) begin
          n_err++;
          $display("FAIL midrst drop: got %h expected %h", av & mk, ev & mk);
        end
      end
      next_cycle();
    end
    sample("RESET", 0, -1, -1, av, ev, mk);
    n_vec++;
    if ((av & mk) !== (ev & mk)) begin
      n_err++;
      $display("FAIL midrst hold: got %h expected %h", av & mk, ev & mk);
    end
    next_cycle();
    reset = 1;
    op = 6'h08;
    build_seq(op, funct, 1);
    foreach (seq[i]) begin
      sample(seq[i], 0, -1, -1, av, ev, mk);
      n_vec++;
      if ((av & mk) !== (ev & mk)) begin
        n_err++;
        $display("FAIL midrst addi %s: got %h expected %h", seq[i], av & mk, ev & mk);
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    vec_t av, ev, mk;
    logic [5:0] opl[7] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h06, 6'h08, 6'h02};
    logic [5:0] fnl[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
    for (int n = 0; n < 40; n++) begin
      op    = ($urandom_range(7, 0) == 0) ? 6'($urandom) : opl[$urandom_range(6, 0)];
      funct = ($urandom_range(3, 0) == 0) ? 6'($urandom) : fnl[$urandom_range(5, 0)];
      build_seq(op, funct, 1);
      foreach (seq[i]) begin
        sample(seq[i], 0, -1, -1, av, ev, mk);
        n_vec++;
        if ((av & mk) !== (ev & mk)) begin
          n_err++;
          $display("FAIL random op=%h f=%h %s: got %h expected %h", op, funct, seq[i], av & mk, ev & mk);
        end
        next_cycle();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_blez();
    test_blez_disabled();
    test_illegal();
    test_midop_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
